hazard5_ahbl_arb_2to1: RTL and testbench

// Two-master to one-slave AHB-Lite arbiter. Sits directly downstream of the dual-port CPU wrapper.
// - CPU instruction port (i_*) and load/store port (d_*) terminate on this block as AHB-Lite slaves.
// - Both share one downstream AHB-Lite master port (m_*), e.g. to a single SRAM or bus fabric.
// - An address phase that loses arbitration is captured in a per-port buffer.
// - The losing master is stalled via its HREADY until the buffered transfer completes downstream.
//

---
 rtl/hazard5_ahbl_arb_2to1_if.sv | 28 ++
 rtl/hazard5_ahbl_arb_2to1.sv | 147 ++++++++++++++
 tb/tb_hazard5_ahbl_arb_2to1.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard5_ahbl_arb_2to1_if.sv
// AHB-Lite address/data-phase signal bundle shared by upstream and downstream arbiter ports.
// The master modport drives the address phase and write data; the slave modport returns HREADY/HRESP/HRDATA.
interface hazard5_ahbl_arb_2to1_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/hazard5_ahbl_arb_2to1.sv
// Two-master (i/d) to one-slave AHB-Lite arbiter; uncontended address phases pass through with zero added latency.
// A losing address phase is parked in a one-entry per-port buffer and its master is stalled via HREADY until issued.
module hazard5_ahbl_arb_2to1 #(
    parameter int W_ADDR     = 32,
    parameter int W_DATA     = 32,
    parameter int D_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard5_ahbl_arb_2to1_if.slave  i_ahb,
    hazard5_ahbl_arb_2to1_if.slave  d_ahb,
    hazard5_ahbl_arb_2to1_if.master m_ahb
);

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              lock;
    } aph_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    aph_t   live_aph_i, live_aph_d;
    aph_t   ibuf_aph_q, ibuf_aph_d, dbuf_aph_q, dbuf_aph_d;
    aph_t   aph_i, aph_d, aph_m;
    logic   ibuf_vld_q, ibuf_vld_d, dbuf_vld_q, dbuf_vld_d;
    logic   rr_i_last_q, rr_i_last_d;
    owner_t owner_q, owner_d;

    logic   i_hready, d_hready;
    logic   live_i, live_d, req_i, req_d;
    logic   conflict, grant_i, grant_d, issue;
    logic   [W_DATA-1:0] hwdata_m;
    logic   unused_htrans0;

    assign unused_htrans0 = i_ahb.htrans[0] ^ d_ahb.htrans[0];

    assign live_aph_i = {i_ahb.haddr, i_ahb.hwrite, i_ahb.hsize, i_ahb.hburst, i_ahb.hprot, i_ahb.hmastlock};
    assign live_aph_d = {d_ahb.haddr, d_ahb.hwrite, d_ahb.hsize, d_ahb.hburst, d_ahb.hprot, d_ahb.hmastlock};

    // A port is stalled only while its buffer waits; the data-phase owner follows the downstream slave.
    always_comb begin
        i_hready = (owner_q == OWN_I) ? m_ahb.hready : ~ibuf_vld_q;
        d_hready = (owner_q == OWN_D) ? m_ahb.hready : ~dbuf_vld_q;
    end

    assign live_i = i_ahb.htrans[1] & i_hready;
    assign live_d = d_ahb.htrans[1] & d_hready;
    assign req_i  = live_i | ibuf_vld_q;
    assign req_d  = live_d | dbuf_vld_q;
    assign aph_i  = ibuf_vld_q ? ibuf_aph_q : live_aph_i;
    assign aph_d  = dbuf_vld_q ? dbuf_aph_q : live_aph_d;

    always_comb begin
        conflict = req_i & req_d;
        if (conflict) begin
            grant_d = (D_PRIORITY != 0) || rr_i_last_q;
        end else begin
            grant_d = req_d;
        end
        grant_i = req_i & ~grant_d;
        issue   = m_ahb.hready & (req_i | req_d);
        aph_m   = (issue && grant_i) ? aph_i : aph_d;
    end

    assign m_ahb.haddr     = aph_m.addr;
    assign m_ahb.hwrite    = aph_m.write;
    assign m_ahb.hsize     = aph_m.size;
    assign m_ahb.hburst    = aph_m.burst;
    assign m_ahb.hprot     = aph_m.prot;
    assign m_ahb.hmastlock = aph_m.lock;
    assign m_ahb.htrans    = issue ? 2'b10 : 2'b00;

    assign hwdata_m        = (owner_q == OWN_I) ? i_ahb.hwdata : d_ahb.hwdata;
    assign m_ahb.hwdata    = hwdata_m;

    assign i_ahb.hready    = i_hready;
    assign d_ahb.hready    = d_hready;
    assign i_ahb.hresp     = (owner_q == OWN_I) & m_ahb.hresp;
    assign d_ahb.hresp     = (owner_q == OWN_D) & m_ahb.hresp;
    assign i_ahb.hrdata    = m_ahb.hrdata;
    assign d_ahb.hrdata    = m_ahb.hrdata;

    always_comb begin
        ibuf_vld_d  = ibuf_vld_q;
        ibuf_aph_d  = ibuf_aph_q;
        dbuf_vld_d  = dbuf_vld_q;
        dbuf_aph_d  = dbuf_aph_q;
        owner_d     = owner_q;
        rr_i_last_d = rr_i_last_q;

        // Any live request that does not go out this cycle is captured, whether it lost or the slave stalled.
        if (issue && grant_i) begin
            ibuf_vld_d = 1'b0;
        end else if (live_i) begin
            ibuf_vld_d = 1'b1;
            ibuf_aph_d = live_aph_i;
        end

        if (issue && grant_d) begin
            dbuf_vld_d = 1'b0;
        end else if (live_d) begin
            dbuf_vld_d = 1'b1;
            dbuf_aph_d = live_aph_d;
        end

        if (m_ahb.hready) begin
            if (!issue) begin
                owner_d = OWN_NONE;
            end else if (grant_i) begin
                owner_d = OWN_I;
            end else begin
                owner_d = OWN_D;
            end
        end

        if (issue && conflict) begin
            rr_i_last_d = grant_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_vld_q  <= 1'b0;
            dbuf_vld_q  <= 1'b0;
            ibuf_aph_q  <= '0;
            dbuf_aph_q  <= '0;
            owner_q     <= OWN_NONE;
            rr_i_last_q <= 1'b1;
        end else begin
            ibuf_vld_q  <= ibuf_vld_d;
            dbuf_vld_q  <= dbuf_vld_d;
            ibuf_aph_q  <= ibuf_aph_d;
            dbuf_aph_q  <= dbuf_aph_d;
            owner_q     <= owner_d;
            rr_i_last_q <= rr_i_last_d;
        end
    end

endmodule

// File: tb/tb_hazard5_ahbl_arb_2to1.sv
// Directed bench: stimulus pushes expected downstream address phases into per-DUT queues that a negedge
// monitor pops as transfers appear; upstream HREADY/HRESP/data are checked cycle by cycle.
module tb_hazard5_ahbl_arb_2to1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard5_ahbl_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) ib1 ();
    hazard5_ahbl_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) db1 ();
    hazard5_ahbl_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) mb1 ();
    hazard5_ahbl_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) ib2 ();
    hazard5_ahbl_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) db2 ();
    hazard5_ahbl_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) mb2 ();

    hazard5_ahbl_arb_2to1 #(.W_ADDR(32), .W_DATA(32), .D_PRIORITY(1)) u_prio (
        .clk   (clk),
        .rst   (rst),
        .i_ahb (ib1),
        .d_ahb (db1),
        .m_ahb (mb1)
    );

    hazard5_ahbl_arb_2to1 #(.W_ADDR(32), .W_DATA(32), .D_PRIORITY(0)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_ahb (ib2),
        .d_ahb (db2),
        .m_ahb (mb2)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  prot;
    } iss_t;

    iss_t exp_q1[$];
    iss_t exp_q2[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [3:0] PROT_I = 4'b0010;
    localparam logic [3:0] PROT_D = 4'b0011;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    function automatic iss_t mk(input logic [31:0] a, input logic wr, input logic [3:0] prot);
        iss_t e;
        e.addr = a;
        e.wr   = wr;
        e.prot = prot;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d1(input logic vld, input logic [31:0] a, input logic wr);
        db1.htrans = vld ? 2'b10 : 2'b00;
        db1.haddr  = a;
        db1.hwrite = wr;
    endtask

    task automatic i1(input logic vld, input logic [31:0] a);
        ib1.htrans = vld ? 2'b10 : 2'b00;
        ib1.haddr  = a;
    endtask

    task automatic d2(input logic vld, input logic [31:0] a);
        db2.htrans = vld ? 2'b10 : 2'b00;
        db2.haddr  = a;
    endtask

    task automatic i2(input logic vld, input logic [31:0] a);
        ib2.htrans = vld ? 2'b10 : 2'b00;
        ib2.haddr  = a;
    endtask

    // Monitor: every downstream NSEQ must match the next expected address phase, in order.
    initial begin
        iss_t e;
        forever begin
            @(negedge clk);
            if (mb1.htrans[1]) begin
                if (exp_q1.size() == 0) begin
                    n_chk++;
                    $display("FAIL prio unexpected issue: got haddr 0x%08h, want no transfer", mb1.haddr);
                end else begin
                    e = exp_q1.pop_front();
                    chk("prio haddr", mb1.haddr, e.addr);
                    chk("prio hwrite/hprot/hsize", {25'd0, mb1.hwrite, mb1.hprot, mb1.hsize},
                        {25'd0, e.wr, e.prot, 3'd2});
                end
            end
            if (mb2.htrans[1]) begin
                if (exp_q2.size() == 0) begin
                    n_chk++;
                    $display("FAIL rr unexpected issue: got haddr 0x%08h, want no transfer", mb2.haddr);
                end else begin
                    e = exp_q2.pop_front();
                    chk("rr haddr", mb2.haddr, e.addr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ib1.hwrite = 1'b0; ib1.hsize = 3'd2; ib1.hburst = 3'd0; ib1.hprot = PROT_I; ib1.hmastlock = 1'b0; ib1.hwdata = '0;
        db1.hwrite = 1'b0; db1.hsize = 3'd2; db1.hburst = 3'd0; db1.hprot = PROT_D; db1.hmastlock = 1'b0; db1.hwdata = '0;
        ib2.hwrite = 1'b0; ib2.hsize = 3'd2; ib2.hburst = 3'd0; ib2.hprot = PROT_I; ib2.hmastlock = 1'b0; ib2.hwdata = '0;
        db2.hwrite = 1'b0; db2.hsize = 3'd2; db2.hburst = 3'd0; db2.hprot = PROT_D; db2.hmastlock = 1'b0; db2.hwdata = '0;
        d1(0, 0, 0); i1(0, 0); d2(0, 0); i2(0, 0);
        mb1.hready = 1'b1; mb1.hresp = 1'b0; mb1.hrdata = '0;
        mb2.hready = 1'b1; mb2.hresp = 1'b0; mb2.hrdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset m_htrans", {30'd0, mb1.htrans}, 32'd0);
        chk("reset i_hready", {31'd0, ib1.hready}, 32'd1);
        chk("reset d_hready", {31'd0, db1.hready}, 32'd1);
        chk("reset hresp", {30'd0, ib1.hresp, db1.hresp}, 32'd0);
        chk("reset rr m_htrans", {30'd0, mb2.htrans}, 32'd0);

        // Uncontended d read, one wait state downstream
        step(); d1(1, 32'h100, 0); exp_q1.push_back(mk(32'h100, 0, PROT_D));
        @(negedge clk);
        step(); d1(0, 0, 0); mb1.hready = 1'b0; mb1.hrdata = 32'h1234_5678;
        @(negedge clk);
        chk("t1 d_hready wait", {31'd0, db1.hready}, 32'd0);
        chk("t1 i_hready idle port", {31'd0, ib1.hready}, 32'd1);
        step(); mb1.hready = 1'b1;
        @(negedge clk);
        chk("t1 d_hready done", {31'd0, db1.hready}, 32'd1);
        chk("t1 d_hrdata", db1.hrdata, 32'h1234_5678);
        chk("t1 d_hresp", {31'd0, db1.hresp}, 32'd0);

        // Conflict with d priority: i is buffered and issued one cycle later
        step(); d1(1, 32'h200, 0); i1(1, 32'h300);
        exp_q1.push_back(mk(32'h200, 0, PROT_D));
        exp_q1.push_back(mk(32'h300, 0, PROT_I));
        @(negedge clk);
        chk("t2 i_hready at T", {31'd0, ib1.hready}, 32'd1);
        step(); d1(0, 0, 0); i1(0, 0); mb1.hrdata = 32'hAAAA_0001;
        @(negedge clk);
        chk("t2 d_hready T+1", {31'd0, db1.hready}, 32'd1);
        chk("t2 d_hrdata T+1", db1.hrdata, 32'hAAAA_0001);
        chk("t2 i_hready stalled T+1", {31'd0, ib1.hready}, 32'd0);
        step(); mb1.hrdata = 32'hBBBB_0002;
        @(negedge clk);
        chk("t2 i_hready T+2", {31'd0, ib1.hready}, 32'd1);
        chk("t2 i_hrdata T+2", ib1.hrdata, 32'hBBBB_0002);

        // d write with two downstream wait states; i request arriving meanwhile is buffered
        step(); d1(1, 32'h40, 1); exp_q1.push_back(mk(32'h40, 1, PROT_D));
        @(negedge clk);
        step(); d1(0, 0, 0); db1.hwdata = 32'hDEAD_BEEF; ib1.hwdata = 32'h1111_1111;
        i1(1, 32'h500); exp_q1.push_back(mk(32'h500, 0, PROT_I)); mb1.hready = 1'b0;
        @(negedge clk);
        chk("t4 m_hwdata wait1", mb1.hwdata, 32'hDEAD_BEEF);
        chk("t4 d_hready wait1", {31'd0, db1.hready}, 32'd0);
        chk("t4 m_htrans stalled", {30'd0, mb1.htrans}, 32'd0);
        step(); i1(0, 0);
        @(negedge clk);
        chk("t4 m_hwdata wait2", mb1.hwdata, 32'hDEAD_BEEF);
        chk("t4 d_hready wait2", {31'd0, db1.hready}, 32'd0);
        chk("t4 i_hready buffered", {31'd0, ib1.hready}, 32'd0);
        step(); mb1.hready = 1'b1;
        @(negedge clk);
        chk("t4 d_hready done", {31'd0, db1.hready}, 32'd1);
        chk("t4 m_hwdata done", mb1.hwdata, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        chk("t4 m_hwdata i owner", mb1.hwdata, 32'h1111_1111);
        chk("t4 i_hready done", {31'd0, ib1.hready}, 32'd1);
        step(); db1.hwdata = '0; ib1.hwdata = '0;

        // Two-cycle ERROR response on an i transfer
        i1(1, 32'h800); exp_q1.push_back(mk(32'h800, 0, PROT_I));
        @(negedge clk);
        step(); i1(0, 0); mb1.hresp = 1'b1; mb1.hready = 1'b0;
        @(negedge clk);
        chk("t5 err1 i_hresp/i_hready", {30'd0, ib1.hresp, ib1.hready}, 32'b10);
        chk("t5 err1 d_hresp/d_hready", {30'd0, db1.hresp, db1.hready}, 32'b01);
        step(); mb1.hready = 1'b1;
        @(negedge clk);
        chk("t5 err2 i_hresp/i_hready", {30'd0, ib1.hresp, ib1.hready}, 32'b11);
        chk("t5 err2 d_hresp", {31'd0, db1.hresp}, 32'd0);
        step(); mb1.hresp = 1'b0;
        @(negedge clk);
        chk("t5 after i_hresp", {31'd0, ib1.hresp}, 32'd0);

        // Reset while an i request is buffered: the buffered request must never issue
        step(); d1(1, 32'h600, 0); i1(1, 32'h700); exp_q1.push_back(mk(32'h600, 0, PROT_D));
        @(negedge clk);
        step(); d1(0, 0, 0); i1(0, 0); mb1.hready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t6 i_hready buffered pre-reset", {31'd0, ib1.hready}, 32'd0);
        step(); rst = 1'b0; mb1.hready = 1'b1;
        @(negedge clk);
        chk("t6 m_htrans after reset", {30'd0, mb1.htrans}, 32'd0);
        chk("t6 i_hready after reset", {31'd0, ib1.hready}, 32'd1);
        chk("t6 d_hready after reset", {31'd0, db1.hready}, 32'd1);
        chk("t6 i_hresp after reset", {31'd0, ib1.hresp}, 32'd0);
        repeat (3) begin
            step();
            @(negedge clk);
            chk("t6 no stale issue", {30'd0, mb1.htrans}, 32'd0);
        end

        // Round-robin: back-to-back conflicts grant d, i, d, then the leftover i
        step(); d2(1, 32'hA00); i2(1, 32'hB00);
        exp_q2.push_back(mk(32'hA00, 0, PROT_D));
        exp_q2.push_back(mk(32'hB00, 0, PROT_I));
        @(negedge clk);
        step(); d2(1, 32'hC00); i2(0, 0); exp_q2.push_back(mk(32'hC00, 0, PROT_D));
        @(negedge clk);
        chk("t3 rr i_hready stalled", {31'd0, ib2.hready}, 32'd0);
        step(); d2(0, 0); i2(1, 32'hD00); exp_q2.push_back(mk(32'hD00, 0, PROT_I));
        @(negedge clk);
        chk("t3 rr d_hready stalled", {31'd0, db2.hready}, 32'd0);
        chk("t3 rr i_hready open", {31'd0, ib2.hready}, 32'd1);
        step(); i2(0, 0);
        @(negedge clk);
        chk("t3 rr i_hready buffered", {31'd0, ib2.hready}, 32'd0);
        step();
        @(negedge clk);
        chk("t3 rr i_hready done", {31'd0, ib2.hready}, 32'd1);
        repeat (2) step();

        @(negedge clk);
        chk("prio expected issues left", exp_q1.size(), 32'd0);
        chk("rr expected issues left", exp_q2.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
